// File: rtl/matrix_pkg.sv
// matrix_pkg
//  Shared definitions for the streaming matrix transpose engine:
//  default sizes, FSM state encoding and the dimension legality check.
//  Optional feature macro used by the design files: MATRIX_TRANSPOSE_FLAT_OUT_EN
//  (adds a flat, zero-padded view of the transposed matrix).
package matrix_pkg;

  localparam int MAX_DIM_DEF = 5;
  localparam int DATA_W_DEF  = 8;
  localparam int DIM_W_DEF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  // A job is legal when both dimensions are non-zero and fit the buffer.
  function automatic logic dims_ok(input int m, input int n, input int max_dim);
    return (m > 0) && (n > 0) && (m <= max_dim) && (n <= max_dim);
  endfunction

endpackage

// File: rtl/matrix_buffer.sv
// matrix_buffer
//  MAX_DIM x MAX_DIM register array holding the matrix A.
//  Ports:
//    clk, reset          clock, asynchronous active-high reset (clears array)
//    clr                 synchronous clear of the whole array
//    we, wr_row, wr_col  write port, stores wr_data at A[wr_row][wr_col]
//    rd_row, rd_col      combinational read port, rd_data = A[rd_row][rd_col]
//    flat_t              (MATRIX_TRANSPOSE_FLAT_OUT_EN only) A^T zero-padded,
//                        element (i,j) at [(i*MAX_DIM+j)*DATA_W +: DATA_W]
module matrix_buffer
  import matrix_pkg::*;
#(
  parameter int MAX_DIM = MAX_DIM_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DIM_W   = DIM_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [DIM_W-1:0]  wr_row,
  input  logic [DIM_W-1:0]  wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DIM_W-1:0]  rd_row,
  input  logic [DIM_W-1:0]  rd_col,
  output logic [DATA_W-1:0] rd_data
`ifdef MATRIX_TRANSPOSE_FLAT_OUT_EN
  ,
  output logic [MAX_DIM*MAX_DIM*DATA_W-1:0] flat_t
`endif
);

  // Row-major flat view of A, used by the read mux.
  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] cells;

  for (genvar gr = 0; gr < MAX_DIM; gr++) begin : g_row
    for (genvar gc = 0; gc < MAX_DIM; gc++) begin : g_col
      logic [DATA_W-1:0] cell_q;
      logic [DATA_W-1:0] cell_d;
      logic              hit;

      assign hit = we && (wr_row == DIM_W'(gr)) && (wr_col == DIM_W'(gc));

      // Clear wins over a write in the same cycle; it only happens on start.
      always_comb begin
        cell_d = cell_q;
        if (clr)      cell_d = '0;
        else if (hit) cell_d = wr_data;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) cell_q <= '0;
        else       cell_q <= cell_d;
      end

      assign cells[(gr*MAX_DIM+gc)*DATA_W +: DATA_W] = cell_q;
`ifdef MATRIX_TRANSPOSE_FLAT_OUT_EN
      // A[gr][gc] lands at A^T position (gc, gr).
      assign flat_t[(gc*MAX_DIM+gr)*DATA_W +: DATA_W] = cell_q;
`endif
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < MAX_DIM; r++) begin
      for (int c = 0; c < MAX_DIM; c++) begin
        if ((rd_row == DIM_W'(r)) && (rd_col == DIM_W'(c)))
          rd_data = cells[(r*MAX_DIM+c)*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/matrix_transpose_stream.sv
// matrix_transpose_stream
//  Accepts an m x n matrix A as a row-major valid/ready element stream,
//  buffers it and then streams A^T row-major with backpressure.
//  Ports:
//    clk, reset            clock, asynchronous active-high reset
//    start, m_in, n_in     job request (sampled in IDLE only)
//    in_valid/in_ready/in_data     input element stream (LOAD)
//    out_valid/out_ready/out_data/out_last  output element stream (EMIT)
//    m_out, n_out          dimensions of A^T (n, m), held until next accepted start
//    busy                  high in LOAD or EMIT
//    done, err             one-cycle pulses: job finished / start rejected
//    out_matrix            (MATRIX_TRANSPOSE_FLAT_OUT_EN only) flat A^T, zero-padded
//                          at stride MAX_DIM, valid from EMIT entry
module matrix_transpose_stream
  import matrix_pkg::*;
#(
  parameter int MAX_DIM = MAX_DIM_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DIM_W   = DIM_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  m_in,
  input  logic [DIM_W-1:0]  n_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [DIM_W-1:0]  m_out,
  output logic [DIM_W-1:0]  n_out,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef MATRIX_TRANSPOSE_FLAT_OUT_EN
  ,
  output logic [MAX_DIM*MAX_DIM*DATA_W-1:0] out_matrix
`endif
);

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  state_t           state_q, state_d;
  logic [DIM_W-1:0] m_q, m_d;
  logic [DIM_W-1:0] n_q, n_d;
  logic [DIM_W-1:0] m_out_q, m_out_d;
  logic [DIM_W-1:0] n_out_q, n_out_d;
  // One counter pair serves both phases: LOAD walks (r,c) over A,
  // EMIT walks (i,j) over A^T with row_q = i, col_q = j.
  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             buf_clr;
  logic             buf_we;

  // State register and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      n_q     <= '0;
      m_out_q <= '0;
      n_out_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      m_out_q <= m_out_d;
      n_out_q <= n_out_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    n_d     = n_q;
    m_out_d = m_out_q;
    n_out_d = n_out_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    buf_clr = 1'b0;
    buf_we  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (dims_ok(int'(m_in), int'(n_in), MAX_DIM)) begin
            m_d     = m_in;
            n_d     = n_in;
            m_out_d = n_in;
            n_out_d = m_in;
            row_d   = '0;
            col_d   = '0;
            buf_clr = 1'b1;
            state_d = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        if (in_valid) begin
          buf_we = 1'b1;
          if (col_q == n_q - ONE) begin
            col_d = '0;
            if (row_q == m_q - ONE) begin
              row_d   = '0;
              state_d = ST_EMIT;
            end else begin
              row_d = row_q + ONE;
            end
          end else begin
            col_d = col_q + ONE;
          end
        end
      end

      ST_EMIT: begin
        // Inner index j (col_q) runs over the m rows of A.
        if (out_ready) begin
          if (col_q == m_q - ONE) begin
            col_d = '0;
            if (row_q == n_q - ONE) begin
              row_d   = '0;
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              row_d = row_q + ONE;
            end
          end else begin
            col_d = col_q + ONE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    in_ready  = (state_q == ST_LOAD);
    out_valid = (state_q == ST_EMIT);
    busy      = (state_q == ST_LOAD) || (state_q == ST_EMIT);
    out_last  = (state_q == ST_EMIT) && (row_q == n_q - ONE) && (col_q == m_q - ONE);
    m_out     = m_out_q;
    n_out     = n_out_q;
    done      = done_q;
    err       = err_q;
  end

  // Read address is swapped: A^T[i][j] = A[j][i].
  matrix_buffer #(
    .MAX_DIM (MAX_DIM),
    .DATA_W  (DATA_W),
    .DIM_W   (DIM_W)
  ) u_buffer (
    .clk     (clk),
    .reset   (reset),
    .clr     (buf_clr),
    .we      (buf_we),
    .wr_row  (row_q),
    .wr_col  (col_q),
    .wr_data (in_data),
    .rd_row  (col_q),
    .rd_col  (row_q),
    .rd_data (out_data)
`ifdef MATRIX_TRANSPOSE_FLAT_OUT_EN
    ,
    .flat_t  (out_matrix)
`endif
  );

endmodule

// File: tb/tb_matrix_transpose_stream.sv
module tb_matrix_transpose_stream;

  localparam int MAX_DIM = 5;
  localparam int DATA_W  = 8;
  localparam int DIM_W   = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [DIM_W-1:0]  m_in, n_in;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid, out_ready, out_last;
  logic [DATA_W-1:0] out_data;
  logic [DIM_W-1:0]  m_out, n_out;
  logic              busy, done, err;
`ifdef MATRIX_TRANSPOSE_FLAT_OUT_EN
  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] out_matrix;
`endif

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] din_q[$];
  logic [DATA_W-1:0] exp_q[$];

  matrix_transpose_stream #(
    .MAX_DIM (MAX_DIM),
    .DATA_W  (DATA_W),
    .DIM_W   (DIM_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .m_in      (m_in),
    .n_in      (n_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .m_out     (m_out),
    .n_out     (n_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef MATRIX_TRANSPOSE_FLAT_OUT_EN
    ,
    .out_matrix(out_matrix)
`endif
  );

  always #5 clk = ~clk;

  // Builds A (row-major, A[r][c] = base + r*n + c) and pushes A^T order to the scoreboard.
  task automatic load_job(input int m, input int n, input int base);
    din_q.delete();
    exp_q.delete();
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++)
        din_q.push_back(DATA_W'(base + r*n + c));
    for (int i = 0; i < n; i++)
      for (int j = 0; j < m; j++)
        exp_q.push_back(din_q[j*n + i]);
  endtask

  // Starts a job, streams din_q in, pops/compares outputs; returns in the done cycle.
  task automatic run_stream(input int m, input int n, input int in_pct,
                            input int out_pct, input bit poke_start);
    int in_idx = 0;
    int total = m * n;
    int cycles = 0;
    bit final_hs = 0;
    bit prev_stall = 0;
    bit last_in_hs = 0;
    logic [DATA_W-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    logic [DATA_W-1:0] exp_v;

    start = 1'b1; m_in = DIM_W'(m); n_in = DIM_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_accept %0dx%0d: busy=%b in_ready=%b required 1 1", m, n, busy, in_ready);
    end
    checks++;
    if (m_out !== DIM_W'(n) || n_out !== DIM_W'(m)) begin
      errors++;
      $display("FAIL dims_out: m_out=%0d n_out=%0d required %0d %0d", m_out, n_out, n, m);
    end

    forever begin
      if (final_hs) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL done_pulse: done=%b busy=%b required 1 0", done, busy);
        end
        break;
      end
      checks++;
      if (done !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL spurious_pulse: done=%b err=%b required 0 0", done, err);
      end
      if (last_in_hs) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL first_out_latency: out_valid=%b required 1", out_valid);
        end
      end
      if (prev_stall) begin
        checks++;
        if (out_data !== prev_data || out_last !== prev_last) begin
          errors++;
          $display("FAIL stall_hold: data=%0h last=%b required %0h %b",
                   out_data, out_last, prev_data, prev_last);
        end
      end

      if (poke_start && out_valid) begin
        start = 1'b1; m_in = '0; n_in = '0;
      end

      if (in_idx < total) begin
        in_valid = ($urandom_range(99) < in_pct);
        in_data  = in_valid ? din_q[in_idx] : DATA_W'($urandom);
      end else begin
        in_valid = 1'($urandom_range(1));
        in_data  = DATA_W'($urandom);
      end
      out_ready = ($urandom_range(99) < out_pct);

      last_in_hs = 0;
      if (in_valid && in_ready && in_idx < total) begin
        if (in_idx == total - 1) last_in_hs = 1;
        in_idx++;
      end

      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_output: data=%0h required no output", out_data);
          final_hs = 1;
        end else begin
          exp_v = exp_q.pop_front();
          checks++;
          if (out_data !== exp_v) begin
            errors++;
            $display("FAIL out_data: got %0h required %0h", out_data, exp_v);
          end
          checks++;
          if (out_last !== (exp_q.size() == 0)) begin
            errors++;
            $display("FAIL out_last: got %b required %b", out_last, exp_q.size() == 0);
          end
          $display("out %0h last=%b", out_data, out_last);
          if (exp_q.size() == 0) final_hs = 1;
        end
      end

      cycles++;
      if (cycles > 3000) begin
        checks++; errors++;
        $display("FAIL timeout: %0d outputs pending required 0", exp_q.size());
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end

    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (m_out !== DIM_W'(n) || n_out !== DIM_W'(m)) begin
      errors++;
      $display("FAIL dims_hold: m_out=%0d n_out=%0d required %0d %0d", m_out, n_out, n, m);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; m_in = '0; n_in = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    checks++;
    if ({in_ready, out_valid, out_last, busy, done, err} !== 6'b0 ||
        m_out !== '0 || n_out !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_state: ctl=%b m_out=%0d n_out=%0d data=%0h required all 0",
               {in_ready, out_valid, out_last, busy, done, err}, m_out, n_out, out_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic_2x3();
`ifdef MATRIX_TRANSPOSE_FLAT_OUT_EN
    logic [MAX_DIM*MAX_DIM*DATA_W-1:0] exp_flat;
`endif
    load_job(2, 3, 1);
    run_stream(2, 3, 100, 100, 0);
`ifdef MATRIX_TRANSPOSE_FLAT_OUT_EN
    exp_flat = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 2; j++)
        exp_flat[(i*MAX_DIM+j)*DATA_W +: DATA_W] = DATA_W'(j*3 + i + 1);
    checks++;
    if (out_matrix !== exp_flat) begin
      errors++;
      $display("FAIL flat_out: got %h required %h", out_matrix, exp_flat);
    end
`endif
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_bad_start();
    logic [DIM_W-1:0] mo, no;
    int bad_m[2] = '{0, 6};
    mo = m_out; no = n_out;
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; m_in = DIM_W'(bad_m[k]); n_in = DIM_W'(2);
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || m_out !== mo || n_out !== no) begin
        errors++;
        $display("FAIL bad_start m=%0d: err=%b busy=%b m_out=%0d n_out=%0d required 1 0 %0d %0d",
                 bad_m[k], err, busy, m_out, n_out, mo, no);
      end
      @(posedge clk); #1;
      checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL err_width m=%0d: err=%b busy=%b required 0 0", bad_m[k], err, busy);
      end
    end
  endtask

  task automatic test_random_5x5();
    load_job(5, 5, 0);
    run_stream(5, 5, 60, 50, 0);
  endtask

  task automatic test_reset_mid_load();
    load_job(3, 3, 10);
    start = 1'b1; m_in = 3'd3; n_in = 3'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = din_q[k];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, out_last, busy, done, err} !== 6'b0 ||
        m_out !== '0 || n_out !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL mid_reset: ctl=%b m_out=%0d n_out=%0d data=%0h required all 0",
               {in_ready, out_valid, out_last, busy, done, err}, m_out, n_out, out_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle: done=%b busy=%b required 0 0", done, busy);
    end
    load_job(1, 1, 8'hAA);
    run_stream(1, 1, 100, 100, 0);
  endtask

  task automatic test_back_to_back();
    load_job(3, 2, 32);
    run_stream(3, 2, 80, 70, 1);
    // Started in the done cycle of the previous job.
    load_job(2, 2, 64);
    run_stream(2, 2, 100, 100, 0);
  endtask

  initial begin
    test_reset();
    test_basic_2x3();
    test_bad_start();
    test_random_5x5();
    test_reset_mid_load();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
